// File: rtl/pipe_skid_stage_pkg.sv
// Shared pipeline definitions: skid-stage state encodings, common constants
// and the per-boundary bubble payloads handed to pipe_skid_stage as BUBBLE.
package pipe_skid_stage_pkg;

   typedef enum logic [1:0] {
      PS_EMPTY = 2'd0,
      PS_ONE   = 2'd1,
      PS_FULL  = 2'd2
   } ps_state_e;

   localparam logic        RstEnable  = 1'b1;
   localparam logic [31:0] ZeroWord   = 32'h0000_0000;
   localparam logic [4:0]  NOPRegAddr = 5'b00000;
   localparam logic [7:0]  OpNothing  = 8'h00;

   // Bubble payload layout: {unused, reg addr, write enable, op}.
   // Write disabled, NOP register address, OpNothing.
   localparam logic [31:0] BUBBLE_ID_EX = {ZeroWord[31:14], NOPRegAddr, 1'b0, OpNothing};

endpackage

// File: rtl/pipe_skid_stage_sat.sv
// sat_counter: saturating up-counter, reusable for performance monitors.
//   clk  - clock
//   rst  - synchronous active-high clear
//   inc  - count enable; ignored once the count is all-ones
//   cnt  - current count
module sat_counter
   import pipe_skid_stage_pkg::*;
#(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (inc && (cnt_q != {W{1'b1}})) begin
         cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clk) begin
      if (rst == RstEnable) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/pipe_skid_stage.sv
// Pipeline-stage register with a two-entry skid buffer and local valid/ready
// handshake, synchronous flush and a saturating bubble counter.
//   clk, rst          - clock, synchronous active-high reset
//   flush             - squash all held entries (branch redirect)
//   in_valid/in_ready - upstream handshake; in_ready decodes from state only
//   in_data           - upstream payload
//   out_valid/out_ready - downstream handshake
//   out_data          - registered payload, BUBBLE when empty
//   occupancy         - held entries 0..2 (the state encoding itself)
//   bubble_cnt        - saturating count of empty cycles seen by a ready consumer
//
// state    | meaning
// PS_EMPTY | nothing held, out_data = BUBBLE
// PS_ONE   | main holds the head entry
// PS_FULL  | main holds the head, skid holds the next entry; in_ready low
module pipe_skid_stage
   import pipe_skid_stage_pkg::*;
#(
   parameter int               WIDTH  = 32,
   parameter logic [WIDTH-1:0] BUBBLE = {WIDTH{1'b0}},
   parameter int               CNT_W  = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       occupancy,
   output logic [CNT_W-1:0] bubble_cnt
);

   ps_state_e        state_q, state_d;
   logic [WIDTH-1:0] main_q, main_d;
   logic [WIDTH-1:0] skid_q, skid_d;
   logic             in_fire;
   logic             out_fire;

   assign in_ready  = (state_q != PS_FULL);
   assign out_valid = (state_q == PS_ONE) || (state_q == PS_FULL);
   assign in_fire   = in_valid & in_ready;
   assign out_fire  = out_valid & out_ready;

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush) begin
         // Downstream may still take the current head this cycle; we just
         // drop everything held and whatever arrives alongside the flush.
         state_d = PS_EMPTY;
         main_d  = BUBBLE;
      end else begin
         case (state_q)
            PS_EMPTY: begin
               if (in_fire) begin
                  main_d  = in_data;
                  state_d = PS_ONE;
               end
            end
            PS_ONE: begin
               if (in_fire && out_fire) begin
                  main_d = in_data;
               end else if (in_fire) begin
                  skid_d  = in_data;
                  state_d = PS_FULL;
               end else if (out_fire) begin
                  main_d  = BUBBLE;
                  state_d = PS_EMPTY;
               end
            end
            PS_FULL: begin
               if (out_fire) begin
                  main_d  = skid_q;
                  state_d = PS_ONE;
               end
            end
            default: begin
               // Unreachable encoding; fall back to a clean empty stage.
               state_d = PS_EMPTY;
               main_d  = BUBBLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst == RstEnable) begin
         state_q <= PS_EMPTY;
         main_q  <= BUBBLE;
         skid_q  <= BUBBLE;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
      end
   end

   assign out_data  = main_q;
   assign occupancy = state_q;

   sat_counter #(
      .W (CNT_W)
   ) u_bubble_cnt (
      .clk (clk),
      .rst (rst),
      .inc (~out_valid & out_ready),
      .cnt (bubble_cnt)
   );

endmodule
